feedback_rx: RTL and testbench

//  Receive end of the 5-word feedback packet (fsourceID, fbatteryStat, fValue, fclusterID,

---
 rtl/feedback_rx_if.sv | 12 +
 rtl/feedback_rx.sv | 142 ++++++++++++++
 tb/tb_feedback_rx.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/feedback_rx_if.sv
// Word-stream handshake between the radio RX buffer and the feedback packet receiver.
// The master drives packet words; the slave returns in_ready.
interface feedback_rx_if #(
    parameter int WORD_WIDTH = 16
);
    logic                  in_valid;
    logic [WORD_WIDTH-1:0] in_data;
    logic                  in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/feedback_rx.sv
// Receive side of the 5-word feedback packet: parses the word stream, filters on cluster and
// destination, and writes the sender's battery status and value into the node tables.
module feedback_rx #(
    parameter int                    WORD_WIDTH = 16,
    parameter logic [WORD_WIDTH-1:0] BATT_BASE  = 16'h0148,
    parameter logic [WORD_WIDTH-1:0] VAL_BASE   = 16'h01C8,
    parameter logic [WORD_WIDTH-1:0] BCAST_ID   = 16'hFFFF
) (
    input  logic                  clock,
    input  logic                  nreset,
    feedback_rx_if.slave          rx,
    input  logic [WORD_WIDTH-1:0] MY_NODE_ID,
    input  logic [WORD_WIDTH-1:0] MY_CLUSTER_ID,
    output logic [WORD_WIDTH-1:0] address,
    output logic [WORD_WIDTH-1:0] data_out,
    output logic                  wr_en,
    output logic                  done,
    output logic                  accepted,
    output logic [7:0]            drop_count
);

    typedef enum logic [3:0] {
        S_SRC     = 4'd0,
        S_BATT    = 4'd1,
        S_VAL     = 4'd2,
        S_CLU     = 4'd3,
        S_DST     = 4'd4,
        S_CHECK   = 4'd5,
        S_WR_BATT = 4'd6,
        S_WR_VAL  = 4'd7,
        S_DONE    = 4'd8
    } state_t;

    state_t                state_r;
    state_t                next_state_s;
    logic                  in_ready_r;
    logic                  xfer_s;
    logic                  match_s;
    logic                  match_r;
    logic                  next_in_stream_s;
    logic [WORD_WIDTH-1:0] src_r;
    logic [WORD_WIDTH-1:0] batt_r;
    logic [WORD_WIDTH-1:0] val_r;
    logic [WORD_WIDTH-1:0] clu_r;
    logic [WORD_WIDTH-1:0] dst_r;
    logic [WORD_WIDTH-1:0] src_x2_s;

    assign rx.in_ready = in_ready_r;
    assign xfer_s      = rx.in_valid & in_ready_r;
    assign src_x2_s    = {src_r[WORD_WIDTH-2:0], 1'b0};
    assign match_s     = (clu_r == MY_CLUSTER_ID) & ((dst_r == MY_NODE_ID) | (dst_r == BCAST_ID));
    assign next_in_stream_s = (next_state_s == S_SRC) | (next_state_s == S_BATT) |
                              (next_state_s == S_VAL) | (next_state_s == S_CLU) |
                              (next_state_s == S_DST);

    // Next-state decode; word-collecting states advance only on a handshake.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_SRC:     next_state_s = xfer_s ? S_BATT  : S_SRC;
            S_BATT:    next_state_s = xfer_s ? S_VAL   : S_BATT;
            S_VAL:     next_state_s = xfer_s ? S_CLU   : S_VAL;
            S_CLU:     next_state_s = xfer_s ? S_DST   : S_CLU;
            S_DST:     next_state_s = xfer_s ? S_CHECK : S_DST;
            S_CHECK:   next_state_s = match_s ? S_WR_BATT : S_DONE;
            S_WR_BATT: next_state_s = S_WR_VAL;
            S_WR_VAL:  next_state_s = S_DONE;
            S_DONE:    next_state_s = S_SRC;
            default:   next_state_s = S_SRC;
        endcase
    end

    // State register and ready flag; ready stays low for the first S_SRC cycle after a packet.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_r    <= S_SRC;
            in_ready_r <= 1'b0;
        end else begin
            state_r    <= next_state_s;
            in_ready_r <= next_in_stream_s & (state_r != S_DONE);
        end
    end

    // Field registers latch the word that completes each collecting state; match held for S_DONE.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            src_r   <= 16'h0000;
            batt_r  <= 16'h0000;
            val_r   <= 16'h0000;
            clu_r   <= 16'h0000;
            dst_r   <= 16'h0000;
            match_r <= 1'b0;
        end else begin
            if (xfer_s) begin
                case (state_r)
                    S_SRC:   src_r  <= rx.in_data;
                    S_BATT:  batt_r <= rx.in_data;
                    S_VAL:   val_r  <= rx.in_data;
                    S_CLU:   clu_r  <= rx.in_data;
                    S_DST:   dst_r  <= rx.in_data;
                    default: ;
                endcase
            end
            if (state_r == S_CHECK) begin
                match_r <= match_s;
            end
        end
    end

    // Registered memory write port and completion/drop reporting.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            address    <= 16'h0000;
            data_out   <= 16'h0000;
            wr_en      <= 1'b0;
            done       <= 1'b0;
            accepted   <= 1'b0;
            drop_count <= 8'h00;
        end else begin
            wr_en    <= 1'b0;
            done     <= (state_r == S_DONE);
            accepted <= (state_r == S_DONE) & match_r;
            case (state_r)
                S_WR_BATT: begin
                    wr_en    <= 1'b1;
                    address  <= BATT_BASE + src_x2_s;
                    data_out <= batt_r;
                end
                S_WR_VAL: begin
                    wr_en    <= 1'b1;
                    address  <= VAL_BASE + src_x2_s;
                    data_out <= val_r;
                end
                default: ;
            endcase
            if ((state_r == S_DONE) && !match_r && (drop_count != 8'hFF)) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_feedback_rx.sv
// Directed bench for feedback_rx: hand-computed writes, done/accepted timing and drop counting.
module tb_feedback_rx;
    logic        clock;
    logic        nreset;
    logic [15:0] my_node;
    logic [15:0] my_cluster;
    logic [15:0] address;
    logic [15:0] data_out;
    logic        wr_en;
    logic        done;
    logic        accepted;
    logic [7:0]  drop_count;

    int n_cmp = 0;
    int n_err = 0;

    int          wr_cnt;
    logic [15:0] wr_addr [0:1];
    logic [15:0] wr_data [0:1];
    int          wr_cyc  [0:1];
    int          done_cnt;
    int          done_cyc;
    logic        acc_seen;
    logic        rdy_hist [1:10];

    feedback_rx_if #(.WORD_WIDTH(16)) bus ();

    feedback_rx dut (
        .clock(clock), .nreset(nreset), .rx(bus.slave),
        .MY_NODE_ID(my_node), .MY_CLUSTER_ID(my_cluster),
        .address(address), .data_out(data_out), .wr_en(wr_en),
        .done(done), .accepted(accepted), .drop_count(drop_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic send_word(input logic [15:0] w);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        while (!bus.in_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (!bus.in_ready) begin
            n_cmp++; n_err++;
            $display("FAIL ready_timeout: in_ready=%b required 1", bus.in_ready);
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic send_packet(input logic [15:0] src, input logic [15:0] batt,
                               input logic [15:0] val, input logic [15:0] clu,
                               input logic [15:0] dst, input int gap);
        logic [15:0] words [0:4];
        words[0] = src; words[1] = batt; words[2] = val; words[3] = clu; words[4] = dst;
        for (int i = 0; i < 5; i++) begin
            send_word(words[i]);
            if (gap > 0 && i < 4) begin
                bus.in_valid = 1'b0;
                repeat (gap) @(negedge clock);
            end
        end
        bus.in_valid = 1'b0;
    endtask

    // Starts at the falling edge after the last word's handshake edge k; cycle c is after edge k+c.
    task automatic capture();
        wr_cnt = 0; done_cnt = 0; done_cyc = 0; acc_seen = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clock);
            if (wr_en) begin
                if (wr_cnt < 2) begin
                    wr_addr[wr_cnt] = address;
                    wr_data[wr_cnt] = data_out;
                    wr_cyc[wr_cnt]  = c;
                end
                wr_cnt++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = c;
                acc_seen = accepted;
            end
            rdy_hist[c] = bus.in_ready;
        end
    endtask

    task automatic test_reset();
        nreset = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 16'h0000;
        my_node = 16'd5;
        my_cluster = 16'd2;
        repeat (3) @(negedge clock);
        n_cmp++;
        if (bus.in_ready !== 1'b0) begin
            n_err++; $display("FAIL rst_ready_low: got %b want 0", bus.in_ready);
        end
        nreset = 1'b1;
        repeat (5) @(negedge clock);
        n_cmp++;
        if ({bus.in_ready, wr_en, done, accepted} !== 4'b1000) begin
            n_err++; $display("FAIL rst_idle_flags: got %b want 1000", {bus.in_ready, wr_en, done, accepted});
        end
        n_cmp++;
        if (drop_count !== 8'h00 || address !== 16'h0000 || data_out !== 16'h0000) begin
            n_err++; $display("FAIL rst_regs: drop=%h addr=%h data=%h want 0", drop_count, address, data_out);
        end
    endtask

    task automatic test_accept(input string tag, input int gap);
        send_packet(16'd3, 16'h0050, 16'h1234, 16'd2, 16'd5, gap);
        capture();
        n_cmp++;
        if (wr_cnt !== 2) begin
            n_err++; $display("FAIL %s_wr_count: got %0d want 2", tag, wr_cnt);
        end
        n_cmp++;
        if (wr_addr[0] !== 16'h014E || wr_data[0] !== 16'h0050 || wr_cyc[0] !== 2) begin
            n_err++; $display("FAIL %s_batt_wr: got %h@%h c%0d want 0050@014E c2", tag, wr_data[0], wr_addr[0], wr_cyc[0]);
        end
        n_cmp++;
        if (wr_addr[1] !== 16'h01CE || wr_data[1] !== 16'h1234 || wr_cyc[1] !== 3) begin
            n_err++; $display("FAIL %s_val_wr: got %h@%h c%0d want 1234@01CE c3", tag, wr_data[1], wr_addr[1], wr_cyc[1]);
        end
        n_cmp++;
        if (done_cnt !== 1 || done_cyc !== 4 || acc_seen !== 1'b1) begin
            n_err++; $display("FAIL %s_done: got cnt=%0d c%0d acc=%b want cnt=1 c4 acc=1", tag, done_cnt, done_cyc, acc_seen);
        end
        n_cmp++;
        if (rdy_hist[4] !== 1'b0 || rdy_hist[5] !== 1'b1) begin
            n_err++; $display("FAIL %s_ready_return: got c4=%b c5=%b want 0 1", tag, rdy_hist[4], rdy_hist[5]);
        end
    endtask

    task automatic test_drop();
        logic [7:0] exp_drop [0:1];
        logic [15:0] clu_v [0:1];
        logic [15:0] dst_v [0:1];
        exp_drop[0] = 8'd1; exp_drop[1] = 8'd2;
        clu_v[0] = 16'd2; dst_v[0] = 16'd6;
        clu_v[1] = 16'd3; dst_v[1] = 16'd5;
        for (int i = 0; i < 2; i++) begin
            send_packet(16'd3, 16'h0050, 16'h1234, clu_v[i], dst_v[i], 0);
            capture();
            n_cmp++;
            if (wr_cnt !== 0) begin
                n_err++; $display("FAIL drop%0d_no_write: got %0d writes want 0", i, wr_cnt);
            end
            n_cmp++;
            if (done_cnt !== 1 || done_cyc !== 2 || acc_seen !== 1'b0) begin
                n_err++; $display("FAIL drop%0d_done: got cnt=%0d c%0d acc=%b want cnt=1 c2 acc=0", i, done_cnt, done_cyc, acc_seen);
            end
            n_cmp++;
            if (drop_count !== exp_drop[i]) begin
                n_err++; $display("FAIL drop%0d_count: got %0d want %0d", i, drop_count, exp_drop[i]);
            end
        end
    endtask

    task automatic test_broadcast();
        send_packet(16'd0, 16'hAAAA, 16'h5555, 16'd2, 16'hFFFF, 0);
        capture();
        n_cmp++;
        if (wr_cnt !== 2 || wr_addr[0] !== 16'h0148 || wr_data[0] !== 16'hAAAA ||
            wr_addr[1] !== 16'h01C8 || wr_data[1] !== 16'h5555) begin
            n_err++; $display("FAIL bcast_src0: got n=%0d %h@%h %h@%h want 2 AAAA@0148 5555@01C8",
                              wr_cnt, wr_data[0], wr_addr[0], wr_data[1], wr_addr[1]);
        end
        n_cmp++;
        if (acc_seen !== 1'b1 || done_cnt !== 1) begin
            n_err++; $display("FAIL bcast_accept: got acc=%b cnt=%0d want 1 1", acc_seen, done_cnt);
        end
        send_packet(16'hFFFF, 16'h0102, 16'h0304, 16'd2, 16'hFFFF, 0);
        capture();
        n_cmp++;
        if (wr_addr[0] !== 16'h0146 || wr_addr[1] !== 16'h01C6 || wr_data[1] !== 16'h0304) begin
            n_err++; $display("FAIL bcast_wrap: got %h %h data %h want 0146 01C6 0304", wr_addr[0], wr_addr[1], wr_data[1]);
        end
        n_cmp++;
        if (drop_count !== 8'd2) begin
            n_err++; $display("FAIL bcast_drop_hold: got %0d want 2", drop_count);
        end
    endtask

    task automatic test_midpacket_reset();
        send_word(16'd3);
        send_word(16'h0050);
        bus.in_valid = 1'b0;
        nreset = 1'b0;
        @(negedge clock);
        n_cmp++;
        if (bus.in_ready !== 1'b0 || drop_count !== 8'h00 || wr_en !== 1'b0 || done !== 1'b0) begin
            n_err++; $display("FAIL mid_rst_state: got rdy=%b drop=%0d wr=%b done=%b want 0 0 0 0",
                              bus.in_ready, drop_count, wr_en, done);
        end
        nreset = 1'b1;
        @(negedge clock);
        test_accept("after_rst", 0);
    endtask

    task automatic test_saturate();
        int n;
        for (int p = 1; p <= 300; p++) begin
            send_packet(16'd1, 16'h0001, 16'h0002, 16'd9, 16'd5, 0);
            n = 0;
            while (!done && n < 10) begin
                @(negedge clock);
                n++;
            end
            if (!done) begin
                n_cmp++; n_err++;
                $display("FAIL sat_done_timeout: packet %0d done=%b want 1", p, done);
            end
            if (p == 254) begin
                @(negedge clock);
                n_cmp++;
                if (drop_count !== 8'hFE) begin
                    n_err++; $display("FAIL sat_254: got %h want FE", drop_count);
                end
            end
            if (p == 255) begin
                @(negedge clock);
                n_cmp++;
                if (drop_count !== 8'hFF) begin
                    n_err++; $display("FAIL sat_255: got %h want FF", drop_count);
                end
            end
        end
        @(negedge clock);
        n_cmp++;
        if (drop_count !== 8'hFF) begin
            n_err++; $display("FAIL sat_300: got %h want FF", drop_count);
        end
    endtask

    initial begin
        test_reset();
        test_accept("b2b", 0);
        test_drop();
        test_broadcast();
        test_accept("gaps", 3);
        test_midpacket_reset();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: sim time exceeded");
        $fatal(1, "timeout");
    end
endmodule
